// File: rtl/fpu_instr_issue_if.sv
// Host / decode / FPU handshake bundle for fpu_instr_issue.
// master = host+FPU side, slave = issue sequencer.
interface fpu_instr_issue_if #(
  parameter int AW = 3
);
  logic          instr_wr_en;
  logic [31:0]   instr_wr_data;
  logic          start;
  logic          instr_full;
  logic [AW:0]   instr_count;
  logic          busy;
  logic          done;
  logic          err;
  logic [31:0]   Instruction;
  logic          Activation_Signal;
  logic          fpu_active;
  logic          fpu_complete;
  logic          illegal_config;
  logic          halt_req;
  logic [31:0]   fpu_result_1;
  logic [31:0]   fp_result;
  logic          fp_result_vld;

  modport master (
    output instr_wr_en, instr_wr_data, start,
    output fpu_complete, illegal_config,
    output halt_req, fpu_result_1,
    input  instr_full, instr_count, busy,
    input  done, err, Instruction,
    input  Activation_Signal, fpu_active,
    input  fp_result, fp_result_vld
  );

  modport slave (
    input  instr_wr_en, instr_wr_data, start,
    input  fpu_complete, illegal_config,
    input  halt_req, fpu_result_1,
    output instr_full, instr_count, busy,
    output done, err, Instruction,
    output Activation_Signal, fpu_active,
    output fp_result, fp_result_vld
  );
endinterface

// File: rtl/fpu_instr_issue.sv
// FIFO-fed instruction sequencer for the FPU decode stage.
// Optional FP_WAIT watchdog: define ISSUE_TIMEOUT_EN.
module fpu_instr_issue #(
  parameter int DEPTH   = 8,
  parameter int AW      = 3,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  fpu_instr_issue_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_INT_ISS,
    S_FP_WAIT,
    S_NEXT
  } state_t;

  state_t state_q, state_d;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          push, pop, empty, full;

  logic [31:0]   instr_q;
  logic [31:0]   fp_res_q;
  logic          vld_q;
  logic          err_q;

  logic          wait_live;
  logic          fp_done;
  logic          fp_bad;
  logic          tmo_hit;
  logic          fp_exit;
  logic          head_fp;

  function automatic logic is_fp(
    input logic [6:0] op
  );
    unique case (op)
      7'b0000111,
      7'b0100111,
      7'b1000011,
      7'b1000111,
      7'b1001011,
      7'b1001111,
      7'b1010011: is_fp = 1'b1;
      default:    is_fp = 1'b0;
    endcase
  endfunction

  assign empty = (count_q == '0);
  assign full  = (count_q == (AW+1)'(DEPTH));
  assign push  = bus.instr_wr_en & ~full;
  assign pop   = (state_q == S_FETCH);

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr_q] <= bus.instr_wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push)
        wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)
        rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_fp = is_fp(mem[rd_ptr_q][6:0]);

  // halt_req freezes every FP_WAIT exit path
  assign wait_live = (state_q == S_FP_WAIT)
                   & ~bus.halt_req;
  assign fp_bad    = wait_live & bus.illegal_config;
  assign fp_done   = wait_live & bus.fpu_complete
                   & ~bus.illegal_config;

`ifdef ISSUE_TIMEOUT_EN
  logic [7:0] tmo_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      tmo_q <= '0;
    else if (state_q != S_FP_WAIT)
      tmo_q <= '0;
    else if (wait_live && tmo_q != 8'(TIMEOUT))
      tmo_q <= tmo_q + 1'b1;
  end

  assign tmo_hit = wait_live
                 & (tmo_q == 8'(TIMEOUT))
                 & ~bus.fpu_complete
                 & ~bus.illegal_config;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
  assign tmo_hit        = 1'b0;
`endif

  assign fp_exit = fp_done | fp_bad | tmo_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state_q <= S_IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:
        if (bus.start && !empty)
          state_d = S_FETCH;
      S_FETCH:
        state_d = head_fp ? S_FP_WAIT
                          : S_INT_ISS;
      S_INT_ISS:
        state_d = S_NEXT;
      S_FP_WAIT:
        if (fp_exit)
          state_d = S_NEXT;
      S_NEXT:
        state_d = empty ? S_IDLE : S_FETCH;
      default:
        state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_q  <= '0;
      fp_res_q <= '0;
      vld_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      if (pop)
        instr_q <= mem[rd_ptr_q];
      if (fp_done)
        fp_res_q <= bus.fpu_result_1;
      vld_q <= fp_done;
      if (state_q == S_IDLE && bus.start)
        err_q <= 1'b0;
      else if (fp_bad || tmo_hit)
        err_q <= 1'b1;
    end
  end

  always_comb begin
    bus.Instruction       = '0;
    bus.Activation_Signal = 1'b0;
    bus.fpu_active        = 1'b0;
    bus.done              = 1'b0;
    bus.busy              = (state_q != S_IDLE);
    bus.instr_full        = full;
    bus.instr_count       = count_q;
    bus.err               = err_q;
    bus.fp_result         = fp_res_q;
    bus.fp_result_vld     = vld_q;
    unique case (state_q)
      S_IDLE:
        bus.done = bus.start & empty;
      S_INT_ISS: begin
        bus.Instruction       = instr_q;
        bus.Activation_Signal = 1'b1;
      end
      S_FP_WAIT: begin
        bus.Instruction = instr_q;
        bus.fpu_active  = 1'b1;
      end
      S_NEXT:
        bus.done = empty;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fpu_instr_issue.sv
// Directed-vector bench for fpu_instr_issue.
// Optional watchdog vector runs when ISSUE_TIMEOUT_EN is defined.
module tb_fpu_instr_issue;

  localparam int DEPTH   = 8;
  localparam int AW      = 3;
  localparam int TIMEOUT = 255;

  logic clk = 1'b0;
  logic rst;

  int n_run  = 0;
  int n_fail = 0;

  fpu_instr_issue_if #(.AW(AW)) bus ();

  fpu_instr_issue #(
    .DEPTH   (DEPTH),
    .AW      (AW),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] w);
    bus.instr_wr_en   = 1'b1;
    bus.instr_wr_data = w;
    tick();
    bus.instr_wr_en   = 1'b0;
  endtask

  task automatic go();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  int          n;
  int          acts;
  int          bad;
  logic        seen_done;
  logic [31:0] last;

  initial begin
    rst                  = 1'b1;
    bus.instr_wr_en      = 1'b0;
    bus.instr_wr_data    = '0;
    bus.start            = 1'b0;
    bus.fpu_complete     = 1'b0;
    bus.illegal_config   = 1'b0;
    bus.halt_req         = 1'b0;
    bus.fpu_result_1     = '0;
    repeat (3) tick();

    chk("rst_busy",  32'(bus.busy), 0);
    chk("rst_count", 32'(bus.instr_count), 0);
    chk("rst_instr", bus.Instruction, 0);
    chk("rst_err",   32'(bus.err), 0);
    chk("rst_fpact", 32'(bus.fpu_active), 0);
    rst = 1'b0;
    tick();

    // 1: single integer op
    push(32'h0050_0093);
    chk("t1_count", 32'(bus.instr_count), 1);
    go();
    chk("t1_fetch_act", 32'(bus.Activation_Signal), 0);
    chk("t1_busy", 32'(bus.busy), 1);
    tick();
    chk("t1_act", 32'(bus.Activation_Signal), 1);
    chk("t1_instr", bus.Instruction, 32'h0050_0093);
    chk("t1_fpact", 32'(bus.fpu_active), 0);
    tick();
    chk("t1_act_low", 32'(bus.Activation_Signal), 0);
    chk("t1_done", 32'(bus.done), 1);
    chk("t1_next_instr", bus.Instruction, 0);
    tick();
    chk("t1_idle_busy", 32'(bus.busy), 0);
    chk("t1_done_low", 32'(bus.done), 0);

    // 2: FADD.S completes after 10 cycles
    push(32'h0020_8053);
    go();
    tick();
    n = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.fpu_active) n++;
      if (i == 9) begin
        bus.fpu_complete = 1'b1;
        bus.fpu_result_1 = 32'h4040_0000;
      end
      tick();
    end
    bus.fpu_complete = 1'b0;
    chk("t2_act_cycles", 32'(n), 10);
    chk("t2_fpact_low", 32'(bus.fpu_active), 0);
    chk("t2_vld", 32'(bus.fp_result_vld), 1);
    chk("t2_result", bus.fp_result, 32'h4040_0000);
    chk("t2_done", 32'(bus.done), 1);
    tick();
    chk("t2_vld_pulse", 32'(bus.fp_result_vld), 0);

    // 3: overfill by one, then drain
    for (int i = 0; i < DEPTH + 1; i++)
      push(32'h0000_0013 + 32'(i));
    chk("t3_full", 32'(bus.instr_full), 1);
    chk("t3_count", 32'(bus.instr_count), 8);
    go();
    tick();
    chk("t3_full_after_pop", 32'(bus.instr_full), 0);
    acts = 0;
    seen_done = 1'b0;
    last = '0;
    for (int c = 0; c < 40; c++) begin
      if (bus.Activation_Signal) begin
        acts++;
        last = bus.Instruction;
      end
      if (bus.done) begin
        seen_done = 1'b1;
        break;
      end
      tick();
    end
    chk("t3_done_seen", 32'(seen_done), 1);
    chk("t3_acts", 32'(acts), 8);
    chk("t3_last", last, 32'h0000_001a);
    tick();
    chk("t3_count_end", 32'(bus.instr_count), 0);

    // 4: halt_req stall inside FP_WAIT
    push(32'h0020_f0d3);
    go();
    bus.halt_req = 1'b1;
    tick();
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (bus.Instruction !== 32'h0020_f0d3) bad++;
      if (!bus.fpu_active) bad++;
      tick();
    end
    chk("t4_stable", 32'(bad), 0);
    bus.halt_req     = 1'b0;
    bus.fpu_complete = 1'b1;
    bus.fpu_result_1 = 32'h3f80_0000;
    tick();
    bus.fpu_complete = 1'b0;
    chk("t4_err", 32'(bus.err), 0);
    chk("t4_vld", 32'(bus.fp_result_vld), 1);
    chk("t4_result", bus.fp_result, 32'h3f80_0000);
    tick();

    // 5: illegal_config beats fpu_complete
    push(32'h1020_8043);
    go();
    tick();
    tick();
    bus.illegal_config = 1'b1;
    bus.fpu_complete   = 1'b1;
    bus.fpu_result_1   = 32'hdead_beef;
    tick();
    bus.illegal_config = 1'b0;
    bus.fpu_complete   = 1'b0;
    chk("t5_err", 32'(bus.err), 1);
    chk("t5_vld", 32'(bus.fp_result_vld), 0);
    chk("t5_result_kept", bus.fp_result, 32'h3f80_0000);
    chk("t5_done", 32'(bus.done), 1);
    tick();
    chk("t5_err_sticky", 32'(bus.err), 1);
    bus.start = 1'b1;
    #1;
    chk("t5_empty_done", 32'(bus.done), 1);
    tick();
    bus.start = 1'b0;
    chk("t5_err_clr", 32'(bus.err), 0);
    chk("t5_idle", 32'(bus.busy), 0);

    // 6: async reset while waiting on the FPU
    push(32'h0020_8053);
    push(32'h0050_0093);
    go();
    tick();
    tick();
    chk("t6_fpact", 32'(bus.fpu_active), 1);
    #2 rst = 1'b1;
    #1;
    chk("t6_fpact_rst", 32'(bus.fpu_active), 0);
    chk("t6_instr_rst", bus.Instruction, 0);
    chk("t6_busy_rst", 32'(bus.busy), 0);
    chk("t6_count_rst", 32'(bus.instr_count), 0);
    chk("t6_res_rst", bus.fp_result, 0);
    tick();
    rst = 1'b0;
    tick();

`ifdef ISSUE_TIMEOUT_EN
    push(32'h0020_8053);
    go();
    tick();
    n = 0;
    for (int c = 0; c < 400; c++) begin
      if (!bus.fpu_active) break;
      n++;
      tick();
    end
    chk("t7_wait_cycles", 32'(n), TIMEOUT + 1);
    chk("t7_err", 32'(bus.err), 1);
    tick();
`endif

    $display("[TB] %0d tests run, %0d failed",
             n_run, n_fail);
    $finish;
  end

endmodule
